mapping_group_seq: RTL

MAPPING_GROUP_SEQ -- requirements
Module: mapping_group_seq

---
 rtl/mapping_group_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/mapping_group_seq.sv
// mapping_group_seq: bit-plane shift-accumulate of lane sums (rbr or parallel pairs); define MAPPING_GROUP_SAT_EN to saturate instead of wrap
module mapping_group_seq #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W = 8,
  parameter int SHIFT_W = 2,
  parameter int ACC_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_LANES*LANE_W-1:0] output_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        start_i,
  input  logic                        mode_i,
  output logic [ACC_W-1:0]            mapping_group_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        ovf_o
);
  localparam int NPL = 1 << SHIFT_W;
  localparam int SW = LANE_W + $clog2(NUM_LANES);
  localparam int TW = SW + 1;
  localparam int EW = (ACC_W > TW + NPL) ? ACC_W + 2 : TW + NPL + 2;
  typedef enum logic [2:0] {IDLE, CAP1, CAP2, ADD, DONE} state_t;
  state_t state;
  logic mode;
  logic [SHIFT_W-1:0] p;
  logic [SW-1:0] s1, s2, lane_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [TW-1:0] t;
  logic signed [EW-1:0] acc_x, t_x, sum_ext;
  logic [ACC_W-1:0] next_acc;
  logic ovf_now;
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < NUM_LANES; k++) lane_sum = lane_sum + SW'(output_i[k*LANE_W +: LANE_W]);
  end
  assign t = mode ? $signed({1'b0, s1}) - $signed({1'b0, s2}) : $signed({1'b0, s1});
  assign acc_x = acc;
  assign t_x = t;
  assign sum_ext = acc_x + (t_x <<< p);
  // in range iff every bit above the ACC_W sign bit matches it
  assign ovf_now = ~(&sum_ext[EW-1:ACC_W-1] | ~|sum_ext[EW-1:ACC_W-1]);
`ifdef MAPPING_GROUP_SAT_EN
  assign next_acc = ovf_now ? (sum_ext[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : sum_ext[ACC_W-1:0];
`else
  assign next_acc = sum_ext[ACC_W-1:0];
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      mode <= 1'b0;
      p <= '0;
      s1 <= '0;
      s2 <= '0;
      acc <= '0;
      mapping_group_o <= '0;
      ovf_o <= 1'b0;
      in_ready_o <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          acc <= '0;
          ovf_o <= 1'b0;
          p <= '0;
          mode <= mode_i;
          state <= CAP1;
          in_ready_o <= 1'b1;
          busy_o <= 1'b1;
        end
        CAP1: if (in_valid_i) begin
          s1 <= lane_sum;
          state <= mode ? CAP2 : ADD;
          in_ready_o <= mode;
        end
        CAP2: if (in_valid_i) begin
          s2 <= lane_sum;
          state <= ADD;
          in_ready_o <= 1'b0;
        end
        ADD: begin
          acc <= next_acc;
          ovf_o <= ovf_o | ovf_now;
          if (&p) begin
            state <= DONE;
            out_valid_o <= 1'b1;
            mapping_group_o <= next_acc;
          end else begin
            p <= p + 1'b1;
            state <= CAP1;
            in_ready_o <= 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          state <= IDLE;
          out_valid_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
